// File: rtl/jpu_ram_arbiter_if.sv
// jpu_ram_arbiter_if: requester handshakes plus the RAM pins of the shared block RAM.
interface jpu_ram_arbiter_if #(
   parameter int NB_COL    = 4,
   parameter int COL_WIDTH = 8,
   parameter int ADDR_W    = 10
);
   localparam int DW = NB_COL * COL_WIDTH;
   logic              p0_valid, p0_ready, p0_rvalid;
   logic [ADDR_W-1:0] p0_addr;
   logic [DW-1:0]     p0_rdata;
   logic              p1_valid, p1_ready, p1_rvalid;
   logic [ADDR_W-1:0] p1_addr;
   logic [NB_COL-1:0] p1_be;
   logic [DW-1:0]     p1_wdata, p1_rdata;
   logic [ADDR_W-1:0] ram_addra;
   logic [DW-1:0]     ram_dina, ram_douta;
   logic [NB_COL-1:0] ram_wea;
   logic              ram_ena, ram_regcea, ram_rsta;
   modport slave (
      input  p0_valid, p0_addr, p1_valid, p1_addr, p1_be, p1_wdata, ram_douta,
      output p0_ready, p0_rvalid, p0_rdata, p1_ready, p1_rvalid, p1_rdata,
             ram_addra, ram_dina, ram_wea, ram_ena, ram_regcea, ram_rsta
   );
   modport master (
      output p0_valid, p0_addr, p1_valid, p1_addr, p1_be, p1_wdata, ram_douta,
      input  p0_ready, p0_rvalid, p0_rdata, p1_ready, p1_rvalid, p1_rdata,
             ram_addra, ram_dina, ram_wea, ram_ena, ram_regcea, ram_rsta
   );
endinterface

// File: rtl/jpu_ram_arbiter.sv
// jpu_ram_arbiter: round-robin sharing of one read-first byte-write RAM between fetch and load/store.
module jpu_ram_arbiter #(
   parameter int NB_COL    = 4,
   parameter int COL_WIDTH = 8,
   parameter int ADDR_W    = 10,
   parameter int RD_LAT    = 2
) (
   input logic               clka,
   input logic               rsta_n,
   jpu_ram_arbiter_if.slave  bus
);
   localparam int DW = NB_COL * COL_WIDTH;
   logic              last_q, last_d;
   logic              g0, g1, acc;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DW-1:0]     din_q, din_d;
   logic [RD_LAT-1:0] vld_q, vld_d, prt_q, prt_d;

   if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_lat
      $error("jpu_ram_arbiter: RD_LAT must be 1 or 2, got %0d", RD_LAT);
   end

   // last_q=1 means port 1 was last served, so port 0 wins the next tie
   always_comb begin
      g0     = rsta_n && bus.p0_valid && (!bus.p1_valid || last_q);
      g1     = rsta_n && bus.p1_valid && (!bus.p0_valid || !last_q);
      acc    = g0 || g1;
      last_d = acc ? g1 : last_q;
      addr_d = g0 ? bus.p0_addr : g1 ? bus.p1_addr : addr_q;
      din_d  = g1 ? bus.p1_wdata : din_q;
      vld_d  = vld_q << 1;
      vld_d[0] = acc;
      prt_d  = prt_q << 1;
      prt_d[0] = g1;
   end

   always_ff @(posedge clka or negedge rsta_n) begin
      if (!rsta_n) begin
         last_q <= 1'b1;
         addr_q <= '0;
         din_q  <= '0;
         vld_q  <= '0;
         prt_q  <= '0;
      end else begin
         last_q <= last_d;
         addr_q <= addr_d;
         din_q  <= din_d;
         vld_q  <= vld_d;
         prt_q  <= prt_d;
      end
   end

   assign bus.p0_ready   = g0;
   assign bus.p1_ready   = g1;
   assign bus.ram_addra  = addr_d;
   assign bus.ram_dina   = din_d;
   assign bus.ram_wea    = g1 ? bus.p1_be : '0;
   assign bus.ram_ena    = acc;
   assign bus.ram_regcea = (RD_LAT == 2);
   assign bus.ram_rsta   = 1'b0;
   assign bus.p0_rvalid  = vld_q[RD_LAT-1] && !prt_q[RD_LAT-1];
   assign bus.p1_rvalid  = vld_q[RD_LAT-1] && prt_q[RD_LAT-1];
   assign bus.p0_rdata   = bus.ram_douta;
   assign bus.p1_rdata   = bus.ram_douta;
endmodule

// File: tb/tb_jpu_ram_arbiter.sv
// tb_jpu_ram_arbiter: directed vectors against RD_LAT=2 and RD_LAT=1 arbiters fed identical traffic.
module tb_jpu_ram_arbiter;
   logic clk = 1'b0;
   logic rsta_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   always #5 clk = ~clk;

   jpu_ram_arbiter_if #(.NB_COL(4), .COL_WIDTH(8), .ADDR_W(10)) b2 ();
   jpu_ram_arbiter_if #(.NB_COL(4), .COL_WIDTH(8), .ADDR_W(10)) b1 ();
   jpu_ram_arbiter #(.NB_COL(4), .COL_WIDTH(8), .ADDR_W(10), .RD_LAT(2)) dut2 (.clka(clk), .rsta_n(rsta_n), .bus(b2));
   jpu_ram_arbiter #(.NB_COL(4), .COL_WIDTH(8), .ADDR_W(10), .RD_LAT(1)) dut1 (.clka(clk), .rsta_n(rsta_n), .bus(b1));

   assign b1.p0_valid = b2.p0_valid;
   assign b1.p0_addr  = b2.p0_addr;
   assign b1.p1_valid = b2.p1_valid;
   assign b1.p1_addr  = b2.p1_addr;
   assign b1.p1_be    = b2.p1_be;
   assign b1.p1_wdata = b2.p1_wdata;

   function automatic logic [31:0] init_w(input int a);
      return (a == 32'h20) ? 32'h11223344 : (32'hC0DE0000 | a);
   endfunction

   // Read-first byte-write RAM models; contents reload while reset is held
   logic [31:0] mem2 [1024];
   logic [31:0] mem1 [1024];
   logic [31:0] s2;
   always @(posedge clk) begin
      if (!rsta_n) begin
         for (int i = 0; i < 1024; i++) mem2[i] <= init_w(i);
      end else if (b2.ram_ena) begin
         s2 <= mem2[b2.ram_addra];
         for (int b = 0; b < 4; b++) if (b2.ram_wea[b]) mem2[b2.ram_addra][8*b +: 8] <= b2.ram_dina[8*b +: 8];
      end
      if (b2.ram_regcea) b2.ram_douta <= s2;
   end
   always @(posedge clk) begin
      if (!rsta_n) begin
         for (int i = 0; i < 1024; i++) mem1[i] <= init_w(i);
      end else if (b1.ram_ena) begin
         b1.ram_douta <= mem1[b1.ram_addra];
         for (int b = 0; b < 4; b++) if (b1.ram_wea[b]) mem1[b1.ram_addra][8*b +: 8] <= b1.ram_dina[8*b +: 8];
      end
   end

   typedef struct {
      logic        p0v;
      logic [9:0]  p0a;
      logic        p1v;
      logic [9:0]  p1a;
      logic [3:0]  be;
      logic [31:0] wd;
      logic        r0;
      logic        r1;
      logic        v0;
      logic        v1;
      logic [31:0] rd;
      logic [9:0]  ra;
   } vec_t;

   function automatic vec_t mk(input logic p0v, input logic [9:0] p0a, input logic p1v, input logic [9:0] p1a,
                               input logic [3:0] be, input logic [31:0] wd, input logic r0, input logic r1,
                               input logic v0, input logic v1, input logic [31:0] rd, input logic [9:0] ra);
      vec_t v;
      v.p0v = p0v; v.p0a = p0a; v.p1v = p1v; v.p1a = p1a; v.be = be; v.wd = wd;
      v.r0 = r0; v.r1 = r1; v.v0 = v0; v.v1 = v1; v.rd = rd; v.ra = ra;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic p0v, input logic [9:0] p0a, input logic p1v, input logic [9:0] p1a,
                        input logic [3:0] be, input logic [31:0] wd);
      b2.p0_valid = p0v; b2.p0_addr = p0a; b2.p1_valid = p1v;
      b2.p1_addr = p1a; b2.p1_be = be; b2.p1_wdata = wd;
   endtask

   localparam int N = 20;
   vec_t tv [N];

   initial begin
      // arbitration from reset: tie goes to p0 first, then alternates
      tv[0]  = mk(1'b1,10'h001,1'b1,10'h002,4'h0,32'h0, 1'b1,1'b0, 1'b0,1'b0,32'h0,        10'h001);
      tv[1]  = mk(1'b1,10'h001,1'b1,10'h002,4'h0,32'h0, 1'b0,1'b1, 1'b0,1'b0,32'h0,        10'h002);
      tv[2]  = mk(1'b1,10'h001,1'b1,10'h002,4'h0,32'h0, 1'b1,1'b0, 1'b1,1'b0,32'hC0DE0001, 10'h001);
      tv[3]  = mk(1'b1,10'h001,1'b1,10'h002,4'h0,32'h0, 1'b0,1'b1, 1'b0,1'b1,32'hC0DE0002, 10'h002);
      tv[4]  = mk(1'b1,10'h001,1'b1,10'h002,4'h0,32'h0, 1'b1,1'b0, 1'b1,1'b0,32'hC0DE0001, 10'h001);
      tv[5]  = mk(1'b1,10'h001,1'b1,10'h002,4'h0,32'h0, 1'b0,1'b1, 1'b0,1'b1,32'hC0DE0002, 10'h002);
      // p0 alone streaming 0x010
      tv[6]  = mk(1'b1,10'h010,1'b0,10'h000,4'h0,32'h0, 1'b1,1'b0, 1'b1,1'b0,32'hC0DE0001, 10'h010);
      tv[7]  = mk(1'b1,10'h010,1'b0,10'h000,4'h0,32'h0, 1'b1,1'b0, 1'b0,1'b1,32'hC0DE0002, 10'h010);
      tv[8]  = mk(1'b1,10'h010,1'b0,10'h000,4'h0,32'h0, 1'b1,1'b0, 1'b1,1'b0,32'hC0DE0010, 10'h010);
      tv[9]  = mk(1'b1,10'h010,1'b0,10'h000,4'h0,32'h0, 1'b1,1'b0, 1'b1,1'b0,32'hC0DE0010, 10'h010);
      // byte write then read-after-write at 0x020
      tv[10] = mk(1'b0,10'h000,1'b1,10'h020,4'h5,32'hAABBCCDD, 1'b0,1'b1, 1'b1,1'b0,32'hC0DE0010, 10'h020);
      tv[11] = mk(1'b0,10'h000,1'b1,10'h020,4'h0,32'h0, 1'b0,1'b1, 1'b1,1'b0,32'hC0DE0010, 10'h020);
      tv[12] = mk(1'b0,10'h000,1'b0,10'h000,4'h0,32'h0, 1'b0,1'b0, 1'b0,1'b1,32'h11223344, 10'h020);
      tv[13] = mk(1'b0,10'h000,1'b0,10'h000,4'h0,32'h0, 1'b0,1'b0, 1'b0,1'b1,32'h11BB33DD, 10'h020);
      // p0 changes address while losing to p1, then wins with the new address
      tv[14] = mk(1'b1,10'h005,1'b0,10'h000,4'h0,32'h0, 1'b1,1'b0, 1'b0,1'b0,32'h0,        10'h005);
      tv[15] = mk(1'b1,10'h030,1'b1,10'h006,4'h0,32'h0, 1'b0,1'b1, 1'b0,1'b0,32'h0,        10'h006);
      tv[16] = mk(1'b1,10'h031,1'b1,10'h007,4'h0,32'h0, 1'b1,1'b0, 1'b1,1'b0,32'hC0DE0005, 10'h031);
      tv[17] = mk(1'b0,10'h000,1'b0,10'h000,4'h0,32'h0, 1'b0,1'b0, 1'b0,1'b1,32'hC0DE0006, 10'h031);
      tv[18] = mk(1'b0,10'h000,1'b0,10'h000,4'h0,32'h0, 1'b0,1'b0, 1'b1,1'b0,32'hC0DE0031, 10'h031);
      tv[19] = mk(1'b0,10'h000,1'b0,10'h000,4'h0,32'h0, 1'b0,1'b0, 1'b0,1'b0,32'h0,        10'h031);

      drive(1'b1, 10'h3FF, 1'b1, 10'h3FE, 4'hF, 32'hFFFFFFFF);
      repeat (3) @(negedge clk);
      #1;
      chk("rst p0_ready", b2.p0_ready, 0);
      chk("rst p1_ready", b2.p1_ready, 0);
      chk("rst ram_ena", b2.ram_ena, 0);
      chk("rst ram_wea", b2.ram_wea, 0);
      chk("rst ram_addra", b2.ram_addra, 0);
      chk("rst ram_dina", b2.ram_dina, 0);
      chk("rst p0_rvalid", b2.p0_rvalid, 0);
      chk("rst p1_rvalid", b2.p1_rvalid, 0);
      chk("rst ram_rsta", b2.ram_rsta, 0);
      chk("rst lat1 ram_ena", b1.ram_ena, 0);
      drive(1'b0, 10'h0, 1'b0, 10'h0, 4'h0, 32'h0);
      @(negedge clk);
      rsta_n = 1'b1;

      for (int k = 0; k < N; k++) begin
         @(negedge clk);
         drive(tv[k].p0v, tv[k].p0a, tv[k].p1v, tv[k].p1a, tv[k].be, tv[k].wd);
         #1;
         chk($sformatf("v%0d p0_ready", k), b2.p0_ready, tv[k].r0);
         chk($sformatf("v%0d p1_ready", k), b2.p1_ready, tv[k].r1);
         chk($sformatf("v%0d ram_ena", k), b2.ram_ena, tv[k].r0 | tv[k].r1);
         chk($sformatf("v%0d ram_wea", k), b2.ram_wea, tv[k].r1 ? tv[k].be : 4'h0);
         chk($sformatf("v%0d ram_addra", k), b2.ram_addra, tv[k].ra);
         chk($sformatf("v%0d ram_regcea", k), b2.ram_regcea, 1);
         chk($sformatf("v%0d p0_rvalid", k), b2.p0_rvalid, tv[k].v0);
         chk($sformatf("v%0d p1_rvalid", k), b2.p1_rvalid, tv[k].v1);
         if (tv[k].v0) chk($sformatf("v%0d p0_rdata", k), b2.p0_rdata, tv[k].rd);
         if (tv[k].v1) chk($sformatf("v%0d p1_rdata", k), b2.p1_rdata, tv[k].rd);
         if (tv[k].r1 && tv[k].be != 4'h0) chk($sformatf("v%0d ram_dina", k), b2.ram_dina, tv[k].wd);
         // the single-cycle build answers one cycle earlier than the two-cycle one
         if (k + 1 < N) begin
            chk($sformatf("v%0d lat1 p0_rvalid", k), b1.p0_rvalid, tv[k+1].v0);
            chk($sformatf("v%0d lat1 p1_rvalid", k), b1.p1_rvalid, tv[k+1].v1);
            if (tv[k+1].v0) chk($sformatf("v%0d lat1 p0_rdata", k), b1.p0_rdata, tv[k+1].rd);
            if (tv[k+1].v1) chk($sformatf("v%0d lat1 p1_rdata", k), b1.p1_rdata, tv[k+1].rd);
         end
      end

      // reset with two reads in flight: responses dropped, tie goes back to p0
      @(negedge clk);
      drive(1'b1, 10'h008, 1'b0, 10'h0, 4'h0, 32'h0);
      #1 chk("inflight accept 0", b2.p0_ready, 1);
      @(negedge clk);
      drive(1'b1, 10'h009, 1'b0, 10'h0, 4'h0, 32'h0);
      #1 chk("inflight accept 1", b2.p0_ready, 1);
      @(negedge clk);
      drive(1'b0, 10'h0, 1'b0, 10'h0, 4'h0, 32'h0);
      rsta_n = 1'b0;
      #1;
      chk("rst drop p0_rvalid", b2.p0_rvalid, 0);
      chk("rst drop lat1 p0_rvalid", b1.p0_rvalid, 0);
      chk("rst drop ram_addra", b2.ram_addra, 0);
      repeat (2) begin
         @(negedge clk);
         #1 chk("rst hold p0_rvalid", b2.p0_rvalid, 0);
      end
      rsta_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         #1;
         chk("post rst p0_rvalid", b2.p0_rvalid, 0);
         chk("post rst p1_rvalid", b2.p1_rvalid, 0);
         chk("post rst lat1 p0_rvalid", b1.p0_rvalid, 0);
      end
      @(negedge clk);
      drive(1'b1, 10'h00A, 1'b1, 10'h00B, 4'h0, 32'h0);
      #1;
      chk("post rst tie p0_ready", b2.p0_ready, 1);
      chk("post rst tie p1_ready", b2.p1_ready, 0);
      chk("post rst tie ram_addra", b2.ram_addra, 10'h00A);
      @(negedge clk);
      drive(1'b0, 10'h0, 1'b0, 10'h0, 4'h0, 32'h0);
      #1 chk("post rst tie p1 next", b2.p1_ready, 0);
      @(negedge clk);
      #1;
      chk("post rst tie p0_rvalid", b2.p0_rvalid, 1);
      chk("post rst tie p0_rdata", b2.p0_rdata, 32'hC0DE000A);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
